screen_sequencer: RTL and testbench
===================================

Name: screen_sequencer

Overview:
- Top-level game-flow controller for the World of Tank display path.
- Sits directly upstream of the pixel colorizer and generates its one-hot frame enables (enable1..enable5) and the three-deep winner history (His1..His3).
- Consumes debounced player buttons, base-destroyed flags from game logic, and a once-per-frame tick from the display timing generator.
- Emits a one-cycle game_reset pulse whenever a new round starts.

Parameters:
- WIN_FRAMES, 180, number of frame_tick pulses the winner screen is held (3 s at 60 Hz); legal range 1..4095.
- CNT_W, 12, width of the frame counter; must satisfy 2^CNT_W > WIN_FRAMES.

Ports:
- clock  in  1  system pixel clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per video frame (end of active video).
- start_btn  in  1  debounced start button, level.
- hist_btn  in  1  debounced history button, level.
- red_base_hit  in  1  red base destroyed (green wins), level, sampled only in GAME.
- green_base_hit  in  1  green base destroyed (red wins), level, sampled only in GAME.
- enable1  out  1  initial/title frame.
- enable2  out  1  game frame.
- enable3  out  1  green-winner frame.
- enable4  out  1  red-winner frame.
- enable5  out  1  history frame.
- His1  out  2  newest result: 00 empty, 01 green, 10 red, 11 draw.
- His2  out  2  previous result.
- His3  out  2  oldest result.
- game_reset  out  1  one-cycle pulse; re-initialises tanks, bullets, monsters and map.

Behaviour:
- Reset (synchronous): state=INIT; enable1=1, enable2..5=0; His1..His3=00; game_reset=0; frame counter=0; button edge registers=0.
- Button rising edges are detected internally (one register per button, reset 0). Only rising edges act; held levels do nothing.
- States:
  - INIT: start edge -> GAME (game_reset=1 for one cycle). hist edge -> HIST. If both edges arrive in the same cycle, start wins.
  - GAME: red_base_hit only -> WIN_G. green_base_hit only -> WIN_R. Both in the same cycle -> HIST with result 11 (draw). Buttons are ignored.
  - WIN_G / WIN_R: the frame counter clears on entry and increments on each frame_tick. When the count reaches WIN_FRAMES-1 and frame_tick is high -> HIST. Buttons are ignored.
  - HIST: start edge -> GAME with a game_reset pulse. hist edge -> INIT.
- History update: on the GAME exit transition only, shift His3<=His2, His2<=His1, His1<=result (01/10/11) in the same cycle. The oldest entry is discarded.
- Output timing:
  - enable* are registered and strictly one-hot; they change in the cycle after the state transition is decided, i.e. 1-cycle latency from the causing input.
  - game_reset is registered; it is high in exactly the same cycle that enable2 first goes high.
- The frame counter saturates and never wraps. It is held at 0 outside WIN_G/WIN_R.
- Reset asserted mid-round or mid-winner-screen: the next cycle is INIT with history cleared; no game_reset pulse.

Decomposition:
- Shared package (tank_pkg):
  - state encoding constants S_INIT, S_GAME, S_WIN_G, S_WIN_R, S_HIST.
  - history codes HIS_EMPTY=2'b00, HIS_GREEN=2'b01, HIS_RED=2'b10, HIS_DRAW=2'b11. The colorizer uses the same codes.
- Natural sub-module: btn_edge (registered rising-edge detector), instantiated twice.
- FSM, counter and history shift register stay in screen_sequencer.

Test Plan:
1. Reset, then start_btn high for 10 cycles -> enable2=1 one cycle after the edge; game_reset high for exactly 1 cycle concurrent with enable2's rise; no re-trigger while held.
2. In GAME, pulse red_base_hit -> enable3=1 next cycle, His1=01; after 180 frame_ticks -> enable5=1; start edge -> enable2, game_reset pulse.
3. Four rounds with results green, red, green, red -> His1=10, His2=01, His3=10; the first green is dropped.
4. red_base_hit and green_base_hit high in the same cycle -> enable5 next cycle, His1=11; enable3/enable4 never assert.
5. In WIN_R at frame count 90, assert reset -> next cycle enable1=1, His1..His3=00, game_reset=0.
6. In INIT, start and hist edges in the same cycle -> GAME. Separately, a hist edge in INIT -> enable5; another hist edge -> enable1. Check one-hot enables on every cycle via assertion.

Source files
------------

// File: rtl/tank_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------
// tank_pkg : screen states, history result codes and enable decode
// Rev 1.0
// ----------------------------------------------------------------------
package tank_pkg;

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_GAME  = 3'd1,
    S_WIN_G = 3'd2,
    S_WIN_R = 3'd3,
    S_HIST  = 3'd4
  } state_t;

  localparam logic [1:0] HIS_EMPTY = 2'b00;
  localparam logic [1:0] HIS_GREEN = 2'b01;
  localparam logic [1:0] HIS_RED   = 2'b10;
  localparam logic [1:0] HIS_DRAW  = 2'b11;

  // Bit k-1 drives enable<k> of the colorizer.
  function automatic logic [4:0] screen_onehot(input state_t s);
    case (s)
      S_INIT:  screen_onehot = 5'b00001;
      S_GAME:  screen_onehot = 5'b00010;
      S_WIN_G: screen_onehot = 5'b00100;
      S_WIN_R: screen_onehot = 5'b01000;
      S_HIST:  screen_onehot = 5'b10000;
      default: screen_onehot = 5'b00001;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/screen_sequencer_if.sv
`default_nettype none
// ----------------------------------------------------------------------
// screen_sequencer_if : game-flow inputs and colorizer-facing outputs
// Rev 1.0
// ----------------------------------------------------------------------
interface screen_sequencer_if;
  logic       frame_tick;
  logic       start_btn;
  logic       hist_btn;
  logic       red_base_hit;
  logic       green_base_hit;
  logic       enable1;
  logic       enable2;
  logic       enable3;
  logic       enable4;
  logic       enable5;
  logic [1:0] His1;
  logic [1:0] His2;
  logic [1:0] His3;
  logic       game_reset;

  modport master (
    output frame_tick, start_btn, hist_btn, red_base_hit, green_base_hit,
    input  enable1, enable2, enable3, enable4, enable5,
    input  His1, His2, His3, game_reset
  );

  modport slave (
    input  frame_tick, start_btn, hist_btn, red_base_hit, green_base_hit,
    output enable1, enable2, enable3, enable4, enable5,
    output His1, His2, His3, game_reset
  );
endinterface
`default_nettype wire

// File: rtl/screen_sequencer_btn_edge.sv
`default_nettype none
// ----------------------------------------------------------------------
// btn_edge : rising-edge detector for a debounced level button
// Rev 1.0
// ----------------------------------------------------------------------
module btn_edge (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic rise
);

  logic btn_prev;

  always_ff @(posedge clock) begin
    if (reset) btn_prev <= 1'b0;
    else       btn_prev <= btn;
  end

  assign rise = btn & ~btn_prev;

endmodule
`default_nettype wire

// File: rtl/screen_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------
// screen_sequencer : game-flow FSM, winner-screen timer, result history
// Rev 1.0
// ----------------------------------------------------------------------
module screen_sequencer
  import tank_pkg::*;
#(
  parameter int WIN_FRAMES = 180,
  parameter int CNT_W      = 12
) (
  input  logic               clock,
  input  logic               reset,
  screen_sequencer_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIN_FRAMES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state, next_state;
  logic [CNT_W-1:0] frame_cnt, cnt_next;
  logic [4:0]       enables;
  logic [1:0]       his1, his2, his3;
  logic [1:0]       result;
  logic             push;
  logic             greset, greset_next;
  logic             start_rise, hist_rise;

  btn_edge u_start_edge (
    .clock (clock),
    .reset (reset),
    .btn   (bus.start_btn),
    .rise  (start_rise)
  );

  btn_edge u_hist_edge (
    .clock (clock),
    .reset (reset),
    .btn   (bus.hist_btn),
    .rise  (hist_rise)
  );

  always_comb begin
    next_state  = state;
    cnt_next    = '0;
    push        = 1'b0;
    result      = HIS_EMPTY;
    greset_next = 1'b0;
    case (state)
      S_INIT: begin
        if (start_rise) begin
          next_state  = S_GAME;
          greset_next = 1'b1;
        end else if (hist_rise) begin
          next_state = S_HIST;
        end
      end
      S_GAME: begin
        if (bus.red_base_hit && bus.green_base_hit) begin
          next_state = S_HIST;
          push       = 1'b1;
          result     = HIS_DRAW;
        end else if (bus.red_base_hit) begin
          next_state = S_WIN_G;
          push       = 1'b1;
          result     = HIS_GREEN;
        end else if (bus.green_base_hit) begin
          next_state = S_WIN_R;
          push       = 1'b1;
          result     = HIS_RED;
        end
      end
      S_WIN_G, S_WIN_R: begin
        cnt_next = frame_cnt;
        if (bus.frame_tick) begin
          if (frame_cnt == CNT_LAST) begin
            next_state = S_HIST;
            cnt_next   = '0;
          end else if (frame_cnt != CNT_MAX) begin
            cnt_next = frame_cnt + CNT_W'(1);
          end
        end
      end
      S_HIST: begin
        if (start_rise) begin
          next_state  = S_GAME;
          greset_next = 1'b1;
        end else if (hist_rise) begin
          next_state = S_INIT;
        end
      end
      default: next_state = S_INIT;
    endcase
  end

  // Enables are decoded from next_state so they land with the state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_INIT;
      enables   <= screen_onehot(S_INIT);
      frame_cnt <= '0;
      greset    <= 1'b0;
      his1      <= HIS_EMPTY;
      his2      <= HIS_EMPTY;
      his3      <= HIS_EMPTY;
    end else begin
      state     <= next_state;
      enables   <= screen_onehot(next_state);
      frame_cnt <= cnt_next;
      greset    <= greset_next;
      if (push) begin
        his3 <= his2;
        his2 <= his1;
        his1 <= result;
      end
    end
  end

  assign bus.enable1    = enables[0];
  assign bus.enable2    = enables[1];
  assign bus.enable3    = enables[2];
  assign bus.enable4    = enables[3];
  assign bus.enable5    = enables[4];
  assign bus.His1       = his1;
  assign bus.His2       = his2;
  assign bus.His3       = his3;
  assign bus.game_reset = greset;

endmodule
`default_nettype wire

// File: tb/tb_screen_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------
// tb_screen_sequencer : directed + randomized bench with screen-flow model
// Rev 1.0
// ----------------------------------------------------------------------
module tb_screen_sequencer;

  localparam int WIN_FRAMES = 180;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  screen_sequencer_if bus ();

  screen_sequencer #(.WIN_FRAMES(WIN_FRAMES), .CNT_W(12)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Reference: current screen number (1..5 = enable index), newest-first results.
  int         m_scr;
  logic [1:0] m_his [3];
  int         m_frames;
  bit         m_prev_start, m_prev_hist, m_greset;

  function automatic void record(input logic [1:0] r);
    m_his[2] = m_his[1];
    m_his[1] = m_his[0];
    m_his[0] = r;
  endfunction

  task automatic model_update();
    bit se, he;
    if (reset) begin
      m_scr = 1; m_frames = 0; m_greset = 0;
      m_prev_start = 0; m_prev_hist = 0;
      for (int i = 0; i < 3; i++) m_his[i] = 2'b00;
      return;
    end
    se = bus.start_btn && !m_prev_start;
    he = bus.hist_btn && !m_prev_hist;
    m_prev_start = bus.start_btn;
    m_prev_hist  = bus.hist_btn;
    m_greset = 0;
    if (m_scr == 1 || m_scr == 5) begin
      if (se) begin m_scr = 2; m_greset = 1; end
      else if (he) m_scr = (m_scr == 1) ? 5 : 1;
    end else if (m_scr == 2) begin
      if (bus.red_base_hit && bus.green_base_hit) begin record(2'b11); m_scr = 5; end
      else if (bus.red_base_hit)   begin record(2'b01); m_scr = 3; end
      else if (bus.green_base_hit) begin record(2'b10); m_scr = 4; end
    end else if (bus.frame_tick) begin
      m_frames++;
      if (m_frames == WIN_FRAMES) begin m_scr = 5; m_frames = 0; end
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] dut_enables();
    return {bus.enable5, bus.enable4, bus.enable3, bus.enable2, bus.enable1};
  endfunction

  task automatic compare_all();
    logic [4:0] exp_en;
    exp_en = 5'(1 << (m_scr - 1));
    check("enables", 8'(dut_enables()), 8'(exp_en));
    check("onehot", 8'($onehot(dut_enables())), 8'd1);
    check("His1", 8'(bus.His1), 8'(m_his[0]));
    check("His2", 8'(bus.His2), 8'(m_his[1]));
    check("His3", 8'(bus.His3), 8'(m_his[2]));
    check("game_reset", 8'(bus.game_reset), 8'(m_greset));
  endtask

  task automatic step();
    @(posedge clock);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic pulse_start();
    bus.start_btn = 1'b1; step();
    bus.start_btn = 1'b0; step();
  endtask

  task automatic pulse_hist();
    bus.hist_btn = 1'b1; step();
    bus.hist_btn = 1'b0; step();
  endtask

  task automatic hit(input bit red, input bit green);
    bus.red_base_hit = red; bus.green_base_hit = green; step();
    bus.red_base_hit = 1'b0; bus.green_base_hit = 1'b0; step();
  endtask

  task automatic run_to_screen(input int target, input int budget);
    for (int i = 0; i < budget && m_scr != target; i++) begin
      bus.frame_tick = 1'($urandom_range(0, 1));
      step();
    end
    bus.frame_tick = 1'b0;
    check("reach_screen", 8'(dut_enables()), 8'(1 << (target - 1)));
  endtask

  initial begin
    bus.frame_tick = 0; bus.start_btn = 0; bus.hist_btn = 0;
    bus.red_base_hit = 0; bus.green_base_hit = 0;
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    step();

    // Start held for 10 cycles: one game_reset only
    bus.start_btn = 1'b1;
    repeat (10) step();
    bus.start_btn = 1'b0;
    step();

    // Green wins, winner screen times out, restart
    hit(1'b1, 1'b0);
    check("his_after_green", 8'(bus.His1), 8'h01);
    run_to_screen(5, 3000);
    pulse_start();

    // Four rounds green, red, green, red
    for (int r = 0; r < 4; r++) begin
      hit(r % 2 == 0, r % 2 == 1);
      run_to_screen(5, 3000);
      pulse_start();
    end
    check("his1_rounds", 8'(bus.His1), 8'h02);
    check("his2_rounds", 8'(bus.His2), 8'h01);
    check("his3_rounds", 8'(bus.His3), 8'h02);

    // Draw goes straight to history
    hit(1'b1, 1'b1);
    check("draw_hist", 8'(bus.His1), 8'h03);

    // Reset in the middle of a red-winner screen
    pulse_start();
    hit(1'b0, 1'b1);
    for (int i = 0; i < 2000 && m_frames != 90; i++) begin
      bus.frame_tick = 1'($urandom_range(0, 1));
      step();
    end
    bus.frame_tick = 1'b0;
    check("win_r_before_reset", 8'(bus.enable4), 8'd1);
    reset = 1'b1; step();
    reset = 1'b0;
    check("mid_reset_his1", 8'(bus.His1), 8'h00);
    step();

    // Simultaneous start+hist in INIT: start wins
    bus.start_btn = 1'b1; bus.hist_btn = 1'b1; step();
    bus.start_btn = 1'b0; bus.hist_btn = 1'b0; step();
    reset = 1'b1; step();
    reset = 1'b0; step();
    pulse_hist();
    check("hist_from_init", 8'(bus.enable5), 8'd1);
    pulse_hist();
    check("init_from_hist", 8'(bus.enable1), 8'd1);

    // Randomized traffic across all screens
    for (int i = 0; i < 3000; i++) begin
      bus.frame_tick     = 1'($urandom_range(0, 1));
      bus.start_btn      = ($urandom_range(0, 15) == 0);
      bus.hist_btn       = ($urandom_range(0, 15) == 0);
      bus.red_base_hit   = ($urandom_range(0, 7) == 0);
      bus.green_base_hit = ($urandom_range(0, 7) == 0);
      reset              = ($urandom_range(0, 499) == 0);
      step();
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
